// File: rtl/dual_port_sync_ram.sv
// Simple-dual-port synchronous RAM: one byte-masked write port and one read port, hardware zero sweep after reset.
// Latency: read data and rd_valid appear READ_LATENCY (1 or 2) cycles after an accepted read; writes land on the accepting edge.
// Backpressure: none once ready=1 (one read and one write per cycle); requests are dropped while ready=0 during the clear sweep.
module dual_port_sync_ram #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_byte_en,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    ready,
  output logic                    addr_err
);

  localparam int NB = DATA_WIDTH / 8;
  // Counter must be able to hold DEPTH itself so it never wraps at the end of the sweep.
  localparam int CW = $clog2(DEPTH + 1);
  // Native array index width; addresses are range-checked before they are narrowed to this.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CW-1:0]       LAST_CLR = CW'(DEPTH - 1);

  // Elaboration-time guards for illegal parameter combinations.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("dual_port_sync_ram: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
    $error("dual_port_sync_ram: DEPTH must be in 1..2**ADDR_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("dual_port_sync_ram: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // One beat of the read pipeline: strobe plus the word it qualifies.
  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] dat;
  } rd_beat_t;

  state_t                state;
  logic [CW-1:0]         clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  wr_oob;
  logic                  rd_oob;
  logic                  wr_hit;
  logic                  mem_we;
  logic [IW-1:0]         mem_idx;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [NB-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] rd_word;
  rd_beat_t              s1;

  // Old word with the enabled bytes of the new word laid over it.
  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Requests only count once the sweep is done; out-of-range addresses are flagged, never aliased.
  assign wr_acc = ready && wr_en;
  assign rd_acc = ready && rd_en;
  assign wr_oob = ({1'b0, wr_addr} >= DEPTH_A);
  assign rd_oob = ({1'b0, rd_addr} >= DEPTH_A);
  assign wr_hit = wr_acc && !wr_oob;

  // Array write port: the clear sweep owns it in CLEAR, user writes own it in IDLE.
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = IW'(wr_addr);
    mem_wd  = wr_data;
    mem_be  = wr_byte_en;
    if (state == CLEAR) begin
      mem_we  = !rst;
      mem_idx = IW'(clr_cnt);
      mem_wd  = '0;
      mem_be  = '1;
    end else if (wr_hit) begin
      mem_we  = 1'b1;
    end
  end

  // Storage itself carries no reset; the sweep provides the zero state.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
      end
    end
  end

  // Read word selection: pre-write array contents, optionally forwarded from a colliding write, zero when out of range.
  always_comb begin
    rd_word = mem[IW'(rd_addr)];
    if ((WRITE_FIRST != 0) && wr_hit && (wr_addr == rd_addr)) begin
      rd_word = byte_merge(rd_word, wr_data, wr_byte_en);
    end
    if (rd_oob) rd_word = '0;
  end

  // Sequencer: zero sweep after reset, then open for traffic; also raises the address-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      ready    <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      // A bad read and a bad write together still produce a single pulse.
      addr_err <= (wr_acc && wr_oob) || (rd_acc && rd_oob);
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + CW'(1);
          if (clr_cnt == LAST_CLR) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          ready <= 1'b1;
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // First read stage: captures the selected word on acceptance; data is held when no read was accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.vld <= rd_acc;
      if (rd_acc) s1.dat <= rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    rd_beat_t s2;

    // Extra output register for timing; forwards a beat only when one is present so rd_data holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2 <= '0;
      end else begin
        s2.vld <= s1.vld;
        if (s1.vld) s2.dat <= s1.dat;
      end
    end

    assign rd_data  = s2.dat;
    assign rd_valid = s2.vld;
  end else begin : g_lat1
    assign rd_data  = s1.dat;
    assign rd_valid = s1.vld;
  end

endmodule

// File: tb/tb_dual_port_sync_ram.sv
// Bench for dual_port_sync_ram: two instances (16 words/latency 1/read-old, 12 words/latency 2/read-new) share one stimulus.
// Expected read beats and error pulses are pushed to per-instance queues when a request is driven, then popped at the cycle they are due.
// Requests are driven #1 after the rising edge; outputs are sampled on the falling edge.
module tb_dual_port_sync_ram;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEP_A = 16;
  localparam int LAT_A = 1;
  localparam int WF_A  = 0;
  localparam int DEP_B = 12;
  localparam int LAT_B = 2;
  localparam int WF_B  = 1;

  typedef struct {
    logic [DW-1:0] dat;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0]    wr_byte_en = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b;
  logic          ready_a, ready_b;
  logic          addr_err_a, addr_err_b;

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            rdy_a = 1 << 30;
  int            rdy_b = 1 << 30;
  logic [DW-1:0] m_a [DEP_A];
  logic [DW-1:0] m_b [DEP_B];
  logic [DW-1:0] hold_a = '0;
  logic [DW-1:0] hold_b = '0;
  exp_t          q_a [$];
  exp_t          q_b [$];
  int            qe_a [$];
  int            qe_b [$];
  logic          ev_a, ev_b, ee_a, ee_b;

  dual_port_sync_ram #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP_A), .READ_LATENCY(LAT_A), .WRITE_FIRST(WF_A)
  ) u_a (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .ready(ready_a), .addr_err(addr_err_a)
  );

  dual_port_sync_ram #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP_B), .READ_LATENCY(LAT_B), .WRITE_FIRST(WF_B)
  ) u_b (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .ready(ready_b), .addr_err(addr_err_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [3:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Falling-edge monitor: every cycle checks ready, rd_valid, rd_data (new or held) and addr_err for both instances.
  always @(negedge clk) begin
    chk("ready_a", DW'(ready_a), DW'(!rst && (cyc >= rdy_a)));
    chk("ready_b", DW'(ready_b), DW'(!rst && (cyc >= rdy_b)));

    ev_a = (q_a.size() > 0) && (q_a[0].cyc == cyc);
    chk("rd_valid_a", DW'(rd_valid_a), DW'(ev_a));
    if (ev_a) begin
      chk("rd_data_a", rd_data_a, q_a[0].dat);
      hold_a = q_a[0].dat;
      void'(q_a.pop_front());
    end else begin
      chk("hold_a", rd_data_a, hold_a);
    end

    ev_b = (q_b.size() > 0) && (q_b[0].cyc == cyc);
    chk("rd_valid_b", DW'(rd_valid_b), DW'(ev_b));
    if (ev_b) begin
      chk("rd_data_b", rd_data_b, q_b[0].dat);
      hold_b = q_b[0].dat;
      void'(q_b.pop_front());
    end else begin
      chk("hold_b", rd_data_b, hold_b);
    end

    ee_a = (qe_a.size() > 0) && (qe_a[0] == cyc);
    chk("addr_err_a", DW'(addr_err_a), DW'(ee_a));
    if (ee_a) void'(qe_a.pop_front());
    ee_b = (qe_b.size() > 0) && (qe_b[0] == cyc);
    chk("addr_err_b", DW'(addr_err_b), DW'(ee_b));
    if (ee_b) void'(qe_b.pop_front());
  end

  // Assert reset for n edges; anything in flight is forgotten and the arrays are expected to read zero after the sweep.
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    q_a.delete(); q_b.delete(); qe_a.delete(); qe_b.delete();
    hold_a = '0;
    hold_b = '0;
    rdy_a  = 1 << 30;
    rdy_b  = 1 << 30;
    foreach (m_a[i]) m_a[i] = '0;
    foreach (m_b[i]) m_b[i] = '0;
    repeat (n) @(posedge clk);
    #1;
    rst   = 1'b0;
    rdy_a = cyc + DEP_A;
    rdy_b = cyc + DEP_B;
  endtask

  // Drive one cycle of requests and record what each instance owes in return.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [3:0] be,
                      input logic re, input logic [AW-1:0] ra);
    logic          bw, br;
    logic [DW-1:0] d;
    @(posedge clk); #1;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_byte_en = be;
    rd_en = re; rd_addr = ra;

    if (cyc >= rdy_a) begin
      bw = int'(wa) >= DEP_A;
      br = int'(ra) >= DEP_A;
      if ((we && bw) || (re && br)) qe_a.push_back(cyc + 1);
      if (re) begin
        d = br ? '0 : m_a[ra];
        if (WF_A != 0 && we && !bw && wa == ra) d = merge(d, wd, be);
        q_a.push_back('{dat: d, cyc: cyc + LAT_A});
      end
      if (we && !bw) m_a[wa] = merge(m_a[wa], wd, be);
    end

    if (cyc >= rdy_b) begin
      bw = int'(wa) >= DEP_B;
      br = int'(ra) >= DEP_B;
      if ((we && bw) || (re && br)) qe_b.push_back(cyc + 1);
      if (re) begin
        d = br ? '0 : m_b[ra];
        if (WF_B != 0 && we && !bw && wa == ra) d = merge(d, wd, be);
        q_b.push_back('{dat: d, cyc: cyc + LAT_B});
      end
      if (we && !bw) m_b[wa] = merge(m_b[wa], wd, be);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 4'h0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    step(1'b1, a, d, be, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, '0, '0, 4'h0, 1'b1, a);
  endtask

  initial begin
    // Reset, then hammer both ports during the sweep: nothing may land, strobe or error.
    do_reset(3);
    for (int i = 0; i < 10; i++) step(1'b1, 4'd2, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'd2);
    idle(6);

    // Whole address space reads back zero; upper four words are out of range on the 12-word instance.
    for (int i = 0; i < 16; i++) rd(AW'(i));

    // Byte-masked overwrite.
    wr(4'd3, 32'hAABB_CCDD, 4'hF);
    wr(4'd3, 32'h1122_3344, 4'h5);
    rd(4'd3);

    // Same-address write and read in one cycle, then a plain read of the result.
    step(1'b1, 4'd5, 32'hDEAD_BEEF, 4'hF, 1'b1, 4'd5);
    rd(4'd5);

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) wr(AW'(i), DW'(16 + i), 4'hF);
    for (int i = 0; i < 4; i++) rd(AW'(i));

    // Out-of-range write/read, aliasing check on word 1, combined bad read+write, all-disabled write, last legal word.
    wr(4'd13, 32'hCAFE_0000, 4'hF);
    rd(4'd13);
    rd(4'd1);
    step(1'b1, 4'd14, 32'h0BAD_0BAD, 4'hF, 1'b1, 4'd15);
    wr(4'd1, 32'hFFFF_FFFF, 4'h0);
    rd(4'd1);
    wr(4'd11, 32'h0B0B_0B0B, 4'hF);
    rd(4'd11);
    step(1'b1, 4'd0, 32'h0000_00A5, 4'h1, 1'b1, 4'd11);
    rd(4'd0);
    idle(4);

    // Reset while a read is in flight; after the rerun sweep the old contents are gone.
    rd(4'd3);
    do_reset(2);
    idle(17);
    rd(4'd3);
    rd(4'd11);
    idle(4);

    chk("drain_a", DW'(q_a.size()), '0);
    chk("drain_b", DW'(q_b.size()), '0);
    chk("drain_err_a", DW'(qe_a.size()), '0);
    chk("drain_err_b", DW'(qe_b.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_port_sync_ram.md
Name: dual_port_sync_ram

Overview:
Parametrised simple-dual-port synchronous RAM with one write port and one read port, sharing a single clock. It succeeds the single-port tri-state RAM and removes the shared inout bus: separate write/read data paths, byte-enable writes, a configurable read pipeline with a valid strobe, and a defined read-during-write policy. After reset, a hardware clear sweep zeroes the array. The block serves as the generic on-chip buffer for datapath and register-file users.

Parameters:
ADDR_WIDTH, 4, address width in bits
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
DEPTH, 16, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from accepted read to rd_valid; legal values 1 or 2
WRITE_FIRST, 0, same-address collision policy: 1 = read returns new data, 0 = read returns old data

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous active-high reset
wr_en  input  1  write request
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
wr_byte_en  input  DATA_WIDTH/8  per-byte write mask; bit i covers data[8i+7:8i]
rd_en  input  1  read request
rd_addr  input  ADDR_WIDTH  read address
rd_data  output  DATA_WIDTH  read data; held between reads
rd_valid  output  1  one-cycle strobe marking rd_data as new
ready  output  1  high when requests are accepted (clear sweep finished)
addr_err  output  1  one-cycle pulse when an accepted request addresses >= DEPTH

Behaviour:
- Reset (rst high, asynchronous): rd_data=0, rd_valid=0, ready=0, addr_err=0, the read pipeline is flushed, and the clear counter is set to 0. The array is not reset asynchronously.
- State machine: CLEAR -> IDLE.
- CLEAR state: starts on the first clock after rst deasserts. Each cycle writes 0 to address clr_cnt, then increments clr_cnt. After writing address DEPTH-1, the next cycle enters IDLE and sets ready=1. The sweep therefore takes DEPTH cycles.
- While ready=0, wr_en and rd_en are ignored: no array change, no rd_valid, no addr_err.
- IDLE state: a write is accepted when wr_en=1. A read is accepted when rd_en=1. Both may be accepted in the same cycle.
- Write: for each i with wr_byte_en[i]=1, mem[wr_addr] byte i takes wr_data byte i. Bytes with wr_byte_en[i]=0 are unchanged. A write with all enables 0 is a no-op.
- Read with READ_LATENCY=1: rd_data and rd_valid update on the edge after acceptance (visible in cycle N+1 for a read accepted in cycle N).
- Read with READ_LATENCY=2: one extra output register; results are visible in cycle N+2.
- Read pipelining: one read per cycle is sustained. rd_valid is high for exactly one cycle per accepted read, in request order.
- Collision (same address, same cycle, both accepted):
  - WRITE_FIRST=1: rd_data is the old word merged with the enabled bytes of wr_data.
  - WRITE_FIRST=0: rd_data is the pre-write word.
- Address >= DEPTH:
  - Write: ignored; addr_err pulses on the next cycle.
  - Read: rd_data=0 with rd_valid still asserted at normal latency; addr_err pulses on the next cycle.
  - Simultaneous bad read and bad write: a single addr_err pulse.
- rd_data holds its last value whenever rd_valid=0. No tri-state anywhere.
- Reset mid-operation: in-flight reads are discarded with no rd_valid. The sweep restarts from address 0, and prior contents are lost (zeroed).
- clr_cnt is wide enough to reach DEPTH without wrap.

Test Plan:
- Reset sweep: assert rst 3 cycles, release -> ready=0 for exactly 16 cycles, then 1. Read all 16 addresses -> every rd_data=0x00000000, 16 rd_valid pulses.
- Byte-enable write: write 0xAABBCCDD to addr 3 with be=4'b1111, then 0x11223344 with be=4'b0101 -> read addr 3 returns 0xAA22CC44 one cycle after the request (READ_LATENCY=1).
- Collision: mem[5]=0x0, same-cycle write 0xDEADBEEF (be=1111) and read of addr 5 -> rd_data=0xDEADBEEF with WRITE_FIRST=1, 0x00000000 with WRITE_FIRST=0. A following read returns 0xDEADBEEF in both cases.
- Back-to-back reads with READ_LATENCY=2: rd_en held 4 cycles on addresses 0,1,2,3 holding 0x10,0x11,0x12,0x13 -> rd_valid high 4 consecutive cycles starting 2 cycles after the first request, data in order.
- Out-of-range with DEPTH=12: write addr 13 then read addr 13 -> two addr_err pulses, rd_data=0 with rd_valid=1, and mem[1] unchanged (no aliasing).
- Reset mid-read: issue read, assert rst before the result appears -> no rd_valid, rd_data=0, ready=0. The sweep reruns and the previously written addr 3 reads back 0.
